gf_hash_acc: RTL and testbench

Polynomial-hash accumulator over GF(2^32) that sits directly upstream of `gmul32` and consumes its products. It accepts a message as a stream of 32-bit words and evaluates Horner's rule, Y ← (Y ⊕ Xᵢ)·H mod m, one word at a time. It drives `gmul32`'s req/a/b/m operands and captures its product on rdy. The final Y is returned on a valid/ready output port, serving hash and MAC engines in the secure pipeline.

---
 rtl/gf_pkg.sv | 35 +++
 rtl/gmul32.sv | 53 +++++
 rtl/gf_hash_acc.sv | 138 +++++++++++++
 tb/tb_gf_hash_acc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared widths, state encoding and the byte-serial GF(2^32) multiply step
// used by the hash accumulator and its multiplier.
package gf_pkg;

    localparam int unsigned GF_W        = 32;
    localparam int unsigned GMUL_CYCLES = 4;
    localparam int unsigned MCNT_W      = $clog2(GMUL_CYCLES);
    localparam int unsigned STEP_BITS   = GF_W / GMUL_CYCLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } gf_acc_state_t;

    // MSB-first shift-and-add over eight coefficients of b, reducing by x^32 + m.
    function automatic logic [GF_W-1:0] gf_step8(
        input logic [GF_W-1:0]      r,
        input logic [GF_W-1:0]      a,
        input logic [STEP_BITS-1:0] bits,
        input logic [GF_W-1:0]      m
    );
        logic [GF_W-1:0] t;
        t = r;
        for (int i = STEP_BITS - 1; i >= 0; i--) begin
            t = {t[GF_W-2:0], 1'b0} ^ (t[GF_W-1] ? m : '0);
            if (bits[i]) begin
                t = t ^ a;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/gmul32.sv
// Four-cycle GF(2^32) multiplier: consumes one byte of b per cycle while req is
// held; rdy and the finished product p are presented in the fourth cycle.
module gmul32
    import gf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [GF_W-1:0] a,
    input  logic [GF_W-1:0] b,
    input  logic [GF_W-1:0] m,
    output logic            rdy,
    output logic [GF_W-1:0] p
);

    localparam logic [MCNT_W-1:0] LAST_STEP = MCNT_W'(GMUL_CYCLES - 1);

    logic [MCNT_W-1:0]    cnt;
    logic [GF_W-1:0]      part_q;
    logic [GF_W-1:0]      part_n;
    logic [STEP_BITS-1:0] bits;

    // Byte of b consumed this cycle, most significant first.
    always_comb begin
        bits = b[31:24];
        case (cnt)
            2'd0:    bits = b[31:24];
            2'd1:    bits = b[23:16];
            2'd2:    bits = b[15:8];
            default: bits = b[7:0];
        endcase
    end

    always_comb begin
        part_n = gf_step8((cnt == '0) ? '0 : part_q, a, bits, m);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            part_q <= '0;
        end else if (req) begin
            cnt    <= MCNT_W'(cnt + 1'b1);
            part_q <= part_n;
        end else begin
            cnt    <= '0;
        end
    end

    assign rdy = req && (cnt == LAST_STEP);
    assign p   = part_n;

endmodule

// File: rtl/gf_hash_acc.sv
// Horner polynomial-hash accumulator over GF(2^32): Y <- (Y ^ X_i) * H mod m,
// one word per multiplier pass, result returned on a valid/ready port.
module gf_hash_acc
    import gf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [GF_W-1:0] key,
    input  logic [GF_W-1:0] m,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [GF_W-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [GF_W-1:0] out_data,
    output logic            busy
);

    localparam logic [MCNT_W-1:0] LAST_STEP = MCNT_W'(GMUL_CYCLES - 1);

    gf_acc_state_t     state;
    gf_acc_state_t     state_n;
    logic [GF_W-1:0]   acc;
    logic [GF_W-1:0]   op_q;
    logic [GF_W-1:0]   key_q;
    logic [GF_W-1:0]   m_q;
    logic              last_q;
    logic [MCNT_W-1:0] mcnt;

    logic              req;
    logic              rdy;
    logic [GF_W-1:0]   p;
    logic              load;
    logic              accept;
    logic              capture;
    logic              mul_done;

    assign req = (state == MUL);
    // The final multiplier cycle is trusted even if rdy is missing.
    assign mul_done = rdy || (mcnt == LAST_STEP);

    gmul32 gmul32_i (
        .clk   (clk),
        .rst_n (~rst),
        .req   (req),
        .a     (op_q),
        .b     (key_q),
        .m     (m_q),
        .rdy   (rdy),
        .p     (p)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    capture = 1'b1;
                    state_n = last_q ? DONE : WAIT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            op_q      <= '0;
            key_q     <= '0;
            m_q       <= '0;
            last_q    <= 1'b0;
            mcnt      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == WAIT);
            out_valid <= (state_n == DONE);
            busy      <= (state_n != IDLE);
            if (load) begin
                key_q <= key;
                m_q   <= m;
                acc   <= '0;
            end
            if (accept) begin
                op_q   <= acc ^ in_data;
                last_q <= in_last;
                mcnt   <= '0;
            end else if (req) begin
                mcnt <= MCNT_W'(mcnt + 1'b1);
            end
            if (capture) begin
                acc <= p;
                if (last_q) begin
                    out_data <= p;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // The multiplier must finish exactly on our last counted cycle.
    always_ff @(posedge clk) begin
        if (!rst && state == MUL && mcnt == LAST_STEP) begin
            assert (rdy)
            else $error("gf_hash_acc: gmul32 rdy missing on final step");
        end
    end
`endif

endmodule

// File: tb/tb_gf_hash_acc.sv
// Scoreboard bench for gf_hash_acc: directed timing/boundary cases followed by
// randomized messages checked against a carry-less-multiply reference model.
module tb_gf_hash_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] key = '0;
    logic [31:0] m = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    bit          rand_ready = 1'b0;
    logic [31:0] msg[16];
    int          msg_len;
    bit          hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    gf_hash_acc dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .m         (m),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full 64-bit carry-less product, then polynomial long division.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] mm);
        logic [63:0] prod;
        logic [63:0] poly;
        prod = '0;
        poly = {32'h0000_0001, mm};
        for (int i = 0; i < 32; i++)
            if (b[i]) prod = prod ^ (64'(a) << i);
        for (int i = 62; i >= 32; i--)
            if (prod[i]) prod = prod ^ (poly << (i - 32));
        return prod[31:0];
    endfunction

    function automatic logic [31:0] ref_hash(input logic [31:0] k, input logic [31:0] mm);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < msg_len; i++)
            y = ref_mul(y ^ msg[i], k, mm);
        return y;
    endfunction

    // Monitor: pops on every output handshake, checks hold stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("out_valid_held", 32'(out_valid), 32'd1);
                check("out_data_held", out_data, hold_d);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %08h expected none", out_data);
                end else begin
                    check("hash", out_data, sb.pop_front());
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        out_ready = v;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge after the start-accepting edge.
    task automatic do_start(input logic [31:0] k, input logic [31:0] mm, input bit timing);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: busy still 1 after %0d cycles", n);
        end
        key   = k;
        m     = mm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (timing) check("in_ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input bit timing, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 after %0d cycles", n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (timing) begin
            for (int i = 1; i <= 4; i++) begin
                check("in_ready_low_during_mul", 32'(in_ready), 32'd0);
                check("out_valid_low_during_mul", 32'(out_valid), 32'd0);
                @(negedge clk);
            end
            check("in_ready_at_t5", 32'(in_ready), 32'(!last));
            check("out_valid_at_t5", 32'(out_valid), 32'(last));
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic run_msg(input logic [31:0] k, input logic [31:0] mm, input bit timing,
                           input bit gaps);
        sb.push_back(ref_hash(k, mm));
        do_start(k, mm, timing);
        for (int i = 0; i < msg_len; i++)
            send_word(msg[i], i == msg_len - 1, timing,
                      (gaps && $urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // in_valid while idle must be ignored
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check("idle_ignores_word", 32'(busy), 32'd0);
        in_valid = 1'b0;

        msg_len = 1; msg[0] = 32'h1234_5678;
        check("model_identity", ref_hash(32'd1, 32'hAF), 32'h1234_5678);
        run_msg(32'd1, 32'h0000_00AF, 1'b1, 1'b0);

        msg_len = 1; msg[0] = 32'h8000_0000;
        check("model_reduction", ref_hash(32'd2, 32'hAF), 32'h0000_00AF);
        run_msg(32'd2, 32'h0000_00AF, 1'b1, 1'b0);

        msg_len = 2; msg[0] = 32'h1234_5678; msg[1] = 32'h0F0F_0F0F;
        check("model_two_word", ref_hash(32'd1, 32'hAF), 32'h1D3B_5977);
        run_msg(32'd1, 32'h0000_00AF, 1'b1, 1'b0);

        msg_len = 3; msg[0] = 32'hDEAD_BEEF; msg[1] = 32'h0BAD_F00D; msg[2] = 32'h5555_AAAA;
        check("model_zero_key", ref_hash(32'd0, 32'h8D), 32'd0);
        run_msg(32'd0, 32'h0000_008D, 1'b0, 1'b0);

        // a word presented together with start must not be consumed
        sb.push_back(32'h0000_FFFF);
        @(negedge clk);
        key = 32'd1; m = 32'hAF; start = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; in_data = 32'hDEAD_0000;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("start_word_not_consumed", 32'(in_ready), 32'd1);
        send_word(32'h0000_FFFF, 1'b1, 1'b1, 0);

        // output backpressure with an ignored start
        set_ready(1'b0);
        msg_len = 2; msg[0] = 32'hA5A5_A5A5; msg[1] = 32'h0000_0001;
        run_msg(32'h1357_9BDF, 32'h0040_0007, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 2);
            key   = 32'd5;
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        start = 1'b0;
        set_ready(1'b1);
        @(negedge clk);
        check("bp_release_idle", 32'(busy), 32'd0);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        msg_len = 1; msg[0] = 32'hCAFE_F00D;
        run_msg(32'h0000_0003, 32'h0000_00AF, 1'b0, 1'b0);

        // reset during the second multiply cycle
        do_start(32'h0000_0003, 32'h0000_00AF, 1'b0);
        in_valid = 1'b1; in_data = 32'h1111_2222; in_last = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_in_ready", 32'(in_ready), 32'd0);
        check("midop_rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midop_no_output", 32'(out_valid), 32'd0);
        msg_len = 2; msg[0] = 32'h1111_2222; msg[1] = 32'h3333_4444;
        run_msg(32'h89AB_CDEF, 32'h0000_001B, 1'b1, 1'b0);

        // randomized messages with input gaps and output stalls
        rand_ready = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            msg_len = int'($urandom_range(16, 1));
            for (int i = 0; i < msg_len; i++) msg[i] = $urandom;
            run_msg($urandom, $urandom, 1'b0, 1'b1);
        end
        rand_ready = 1'b0;
        set_ready(1'b1);

        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
